// File: rtl/spu64_wb_core.sv
// Wishbone slave with four 64-bit RAM banks and a streaming engine that
// writes MEM2 = per-byte sum and MEM3 = XOR of MEM0/MEM1, word by word.
module spu64_wb_core #(
  parameter int WB_ADR_WIDTH = 37,
  parameter int WB_DAT_WIDTH = 64,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH/8,
  parameter int MEM_SIZE     = 1024
) (
  input  logic                    reset,
  input  logic                    clk,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_we_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o
);
  localparam int NUM_LANES = WB_SEL_WIDTH;
  localparam int IW        = $clog2(MEM_SIZE);
  localparam int LW        = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]              vld_pipe;
  logic [WB_ADR_WIDTH-1:0] a_adr;
  logic [WB_DAT_WIDTH-1:0] a_dat;
  logic [NUM_LANES-1:0]    a_sel;
  logic                    a_we;
  logic                    a_reg, a_mem;
  logic [1:0]              a_bank;
  logic [9:0]              a_off;
  logic [IW-1:0]           a_idx;
  logic                    busy, done, commit, stall, start_wr;
  logic [31:0]             len, cycles;
  logic [LW-1:0]           len_eff, len_clip;
  logic [IW-1:0]           idx, wr_idx;
  logic                    wr_vld, last;
  logic [WB_DAT_WIDTH-1:0] rdata;

  logic [3:0][NUM_LANES-1:0][7:0] bank_q, wd;
  logic [3:0][NUM_LANES-1:0]      be;
  logic [3:0][IW-1:0]             wa, ra;
  logic [NUM_LANES-1:0][7:0]      sum, xr;

  assign a_off  = a_adr[9:0];
  assign a_bank = a_adr[11:10];
  assign a_idx  = IW'(a_off);
  assign a_reg  = (a_adr[WB_ADR_WIDTH-1:2] == '0);
  assign a_mem  = (a_adr[WB_ADR_WIDTH-1:13] == '0) && a_adr[12] && (32'(a_off) < MEM_SIZE);

  assign busy     = (state != S_IDLE);
  assign stall    = a_mem && busy;
  assign commit   = vld_pipe[1] && a_we;
  assign start_wr = commit && a_reg && (a_adr[1:0] == 2'd0) && a_sel[0] && a_dat[0];
  assign len_clip = (len > 32'(MEM_SIZE)) ? LW'(MEM_SIZE) : LW'(len);
  assign last     = ({1'b0, idx} == len_eff - LW'(1));

  // vld_pipe[0]: request latched (may stall here), vld_pipe[1]: RAM data ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe   <= '0;
      s_wb_ack_o <= 1'b0;
      s_wb_dat_o <= '0;
      a_adr      <= '0;
      a_dat      <= '0;
      a_sel      <= '0;
      a_we       <= 1'b0;
    end else begin
      s_wb_ack_o <= vld_pipe[1];
      if (s_wb_stb_i && vld_pipe == 2'b00 && !s_wb_ack_o) begin
        vld_pipe <= 2'b01;
        a_adr    <= s_wb_adr_i;
        a_dat    <= s_wb_dat_i;
        a_sel    <= s_wb_sel_i;
        a_we     <= s_wb_we_i;
      end else if (vld_pipe[0] && !stall) begin
        vld_pipe <= 2'b10;
      end else if (vld_pipe[1]) begin
        vld_pipe <= 2'b00;
      end
      if (vld_pipe[1] && !a_we) s_wb_dat_o <= rdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (a_reg) begin
      case (a_adr[1:0])
        2'd0:    rdata[0]    = busy;
        2'd1:    rdata[0]    = done;
        2'd2:    rdata[31:0] = len;
        default: rdata[31:0] = cycles;
      endcase
    end else if (a_mem) begin
      rdata = bank_q[a_bank];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      len    <= 32'd1024;
      cycles <= '0;
    end else begin
      if (state == S_DONE)
        done <= 1'b1;
      else if (start_wr && !busy)
        done <= 1'b0;
      else if (commit && a_reg && a_adr[1:0] == 2'd1 && a_sel[0] && !a_dat[0] && !busy)
        done <= 1'b0;
      if (commit && a_reg && a_adr[1:0] == 2'd2 && a_sel[0]) len <= a_dat[31:0];
      if (start_wr && !busy)
        cycles <= '0;
      else if (busy)
        cycles <= cycles + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_wr) state_nxt = (len_clip == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read of index i in RUN cycle i feeds the MEM2/MEM3 write one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      wr_idx  <= '0;
      wr_vld  <= 1'b0;
      len_eff <= '0;
    end else begin
      wr_vld <= (state == S_RUN);
      wr_idx <= idx;
      if (state == S_IDLE && start_wr) begin
        len_eff <= len_clip;
        idx     <= '0;
      end else if (state == S_RUN && !last) begin
        idx <= idx + IW'(1);
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign sum[l] = bank_q[0][l] + bank_q[1][l];
    assign xr[l]  = bank_q[0][l] ^ bank_q[1][l];
  end

  always_comb begin
    ra[0] = (state == S_RUN) ? idx : a_idx;
    ra[1] = (state == S_RUN) ? idx : a_idx;
    ra[2] = a_idx;
    ra[3] = a_idx;
    for (int g = 0; g < 4; g++) begin
      be[g] = '0;
      wa[g] = a_idx;
      wd[g] = a_dat;
    end
    if (commit && a_mem) be[a_bank] = a_sel;
    if (wr_vld) begin
      be[2] = '1;
      wa[2] = wr_idx;
      wd[2] = sum;
      be[3] = '1;
      wa[3] = wr_idx;
      wd[3] = xr;
    end
  end

  // RAM contents intentionally have no reset
  for (genvar g = 0; g < 4; g++) begin : g_bank
    logic [NUM_LANES-1:0][7:0] mem [MEM_SIZE];
    logic [NUM_LANES-1:0][7:0] q;
    always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_LANES; k++)
        if (be[g][k]) mem[wa[g]][k] <= wd[g][k];
      q <= mem[ra[g]];
    end
    assign bank_q[g] = q;
  end
endmodule
